// File: rtl/glyph_cell_tracker.sv
// Purpose : tracks coarse pixel/scanline position and the 3x3 glyph cell it falls in.
// Latency : one cycle; every output is a register updated on the edge that samples the pulse.
// Backpress: none; frame_start/line_end/pix_en are consumed on every edge they are high.
// Optional build: define GLYPH_DIV3_CHECK_EN to enable the divide-by-3 lookup cross-check.
module glyph_cell_tracker #(
    parameter int XSCALE = 5,
    parameter int YSCALE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       line_end,
    input  logic       pix_en,
    output logic [6:0] px,
    output logic [6:0] py,
    output logic [5:0] col,
    output logic [5:0] row,
    output logic [1:0] sub_x,
    output logic [1:0] sub_y,
    output logic       in_area,
    output logic [6:0] div_in,
    input  logic [5:0] div_q,
    output logic       check_err
);

    localparam logic [3:0] XPRE_MAX  = 4'(XSCALE - 1);
    localparam logic [3:0] YPRE_MAX  = 4'(YSCALE - 1);
    localparam logic [6:0] COORD_MAX = 7'd119;

    logic [3:0] r_xpre, r_ypre;
    logic [6:0] r_px, r_py;
    logic [5:0] r_col, r_row;
    logic [1:0] r_sub_x, r_sub_y;
    logic       r_in_area_x, r_in_area_y, r_in_area;

    logic [3:0] w_xpre_nxt, w_ypre_nxt;
    logic [6:0] w_px_nxt, w_py_nxt;
    logic [5:0] w_col_nxt, w_row_nxt;
    logic [1:0] w_sub_x_nxt, w_sub_y_nxt;
    logic       w_in_area_x_nxt, w_in_area_y_nxt;
    logic       w_ytick;

    // Next-state for both axes; frame_start beats line_end beats pix_en.
    // Quotient/remainder advance together so col/sub_x always equal px/3, px%3.
    always_comb begin
        w_xpre_nxt      = r_xpre;
        w_px_nxt        = r_px;
        w_col_nxt       = r_col;
        w_sub_x_nxt     = r_sub_x;
        w_in_area_x_nxt = r_in_area_x;
        w_ypre_nxt      = r_ypre;
        w_py_nxt        = r_py;
        w_row_nxt       = r_row;
        w_sub_y_nxt     = r_sub_y;
        w_in_area_y_nxt = r_in_area_y;
        w_ytick         = 1'b0;

        if (frame_start) begin
            w_xpre_nxt      = 4'd0;
            w_px_nxt        = 7'd0;
            w_col_nxt       = 6'd0;
            w_sub_x_nxt     = 2'd0;
            w_in_area_x_nxt = 1'b1;
            w_ypre_nxt      = 4'd0;
            w_py_nxt        = 7'd0;
            w_row_nxt       = 6'd0;
            w_sub_y_nxt     = 2'd0;
            w_in_area_y_nxt = 1'b1;
        end else begin
            if (line_end) begin
                w_xpre_nxt      = 4'd0;
                w_px_nxt        = 7'd0;
                w_col_nxt       = 6'd0;
                w_sub_x_nxt     = 2'd0;
                w_in_area_x_nxt = 1'b1;
                w_ytick         = 1'b1;
            end else if (pix_en) begin
                if (r_xpre == XPRE_MAX) begin
                    w_xpre_nxt = 4'd0;
                    if (r_px != COORD_MAX) begin
                        w_px_nxt = r_px + 7'd1;
                        if (r_sub_x == 2'd2) begin
                            w_sub_x_nxt = 2'd0;
                            w_col_nxt   = r_col + 6'd1;
                        end else begin
                            w_sub_x_nxt = r_sub_x + 2'd1;
                        end
                    end else begin
                        // Past the right edge: leave the grid, hold the coordinate.
                        w_in_area_x_nxt = 1'b0;
                    end
                end else begin
                    w_xpre_nxt = r_xpre + 4'd1;
                end
            end

            if (w_ytick) begin
                if (r_ypre == YPRE_MAX) begin
                    w_ypre_nxt = 4'd0;
                    if (r_py != COORD_MAX) begin
                        w_py_nxt = r_py + 7'd1;
                        if (r_sub_y == 2'd2) begin
                            w_sub_y_nxt = 2'd0;
                            w_row_nxt   = r_row + 6'd1;
                        end else begin
                            w_sub_y_nxt = r_sub_y + 2'd1;
                        end
                    end else begin
                        w_in_area_y_nxt = 1'b0;
                    end
                end else begin
                    w_ypre_nxt = r_ypre + 4'd1;
                end
            end
        end
    end

    // Position state; in_area is registered from the next-state flags so it is never combinational.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xpre      <= 4'd0;
            r_px        <= 7'd0;
            r_col       <= 6'd0;
            r_sub_x     <= 2'd0;
            r_in_area_x <= 1'b1;
            r_ypre      <= 4'd0;
            r_py        <= 7'd0;
            r_row       <= 6'd0;
            r_sub_y     <= 2'd0;
            r_in_area_y <= 1'b1;
            r_in_area   <= 1'b1;
        end else begin
            r_xpre      <= w_xpre_nxt;
            r_px        <= w_px_nxt;
            r_col       <= w_col_nxt;
            r_sub_x     <= w_sub_x_nxt;
            r_in_area_x <= w_in_area_x_nxt;
            r_ypre      <= w_ypre_nxt;
            r_py        <= w_py_nxt;
            r_row       <= w_row_nxt;
            r_sub_y     <= w_sub_y_nxt;
            r_in_area_y <= w_in_area_y_nxt;
            r_in_area   <= w_in_area_x_nxt & w_in_area_y_nxt;
        end
    end

    assign px      = r_px;
    assign py      = r_py;
    assign col     = r_col;
    assign row     = r_row;
    assign sub_x   = r_sub_x;
    assign sub_y   = r_sub_y;
    assign in_area = r_in_area;

`ifdef GLYPH_DIV3_CHECK_EN
    logic r_check_err;

    // Sticky mismatch flag: the external px/3 lookup must agree with the tracked column.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_check_err <= 1'b0;
        end else if (r_in_area && (div_q != r_col)) begin
            r_check_err <= 1'b1;
        end
    end

    assign div_in    = r_px;
    assign check_err = r_check_err;
`else
    logic w_unused_div_q;

    assign w_unused_div_q = ^div_q;
    assign div_in         = 7'd0;
    assign check_err      = 1'b0;
`endif

endmodule

// File: tb/tb_glyph_cell_tracker.sv
// Purpose : exercises glyph_cell_tracker against an absolute-count reference model.
// Latency : expectations are queued at drive time and compared 1ns after the sampling edge.
// Backpress: not applicable; the bench drives one stimulus vector per clock.
module tb_glyph_cell_tracker;

    localparam int XS = 5;
    localparam int YS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0;
    logic       line_end = 1'b0;
    logic       pix_en = 1'b0;
    logic [6:0] px, py;
    logic [5:0] col, row;
    logic [1:0] sub_x, sub_y;
    logic       in_area;
    logic [6:0] div_in;
    logic [5:0] div_q;
    logic       check_err;
    logic       force_bad = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model state: raw pulse counts since the last clearing event.
    int  m_xcnt = 0;
    int  m_ycnt = 0;
    logic m_err = 1'b0;

    logic [31:0] sb_q[$];

    glyph_cell_tracker #(.XSCALE(XS), .YSCALE(YS)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_end(line_end),
        .pix_en(pix_en), .px(px), .py(py), .col(col), .row(row), .sub_x(sub_x),
        .sub_y(sub_y), .in_area(in_area), .div_in(div_in), .div_q(div_q),
        .check_err(check_err)
    );

    always #5 clk = ~clk;

    // External divide-by-3 lookup, optionally corrupted.
    assign div_q = force_bad ? 6'd5 : 6'(div_in / 7'd3);

    function automatic logic [31:0] model_vec();
        int xs, ys, pxe, pye;
        logic iax, iay;
        xs  = m_xcnt / XS;
        ys  = m_ycnt / YS;
        pxe = (xs > 119) ? 119 : xs;
        pye = (ys > 119) ? 119 : ys;
        iax = (xs <= 119);
        iay = (ys <= 119);
        return {7'(pxe), 7'(pye), 6'(pxe / 3), 6'(pye / 3), 2'(pxe % 3), 2'(pye % 3),
                iax & iay, m_err};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {px, py, col, row, sub_x, sub_y, in_area, check_err};
    endfunction

    task automatic cycle(input logic fs, input logic le, input logic pe);
        logic [31:0] exp_v, act_v;
        @(negedge clk);
        frame_start = fs;
        line_end    = le;
        pix_en      = pe;
        if (fs) begin
            m_xcnt = 0;
            m_ycnt = 0;
        end else if (le) begin
            m_xcnt = 0;
            m_ycnt = m_ycnt + 1;
        end else if (pe) begin
            m_xcnt = m_xcnt + 1;
        end
        sb_q.push_back(model_vec());
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        line_end    = 1'b0;
        pix_en      = 1'b0;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            exp_v = sb_q.pop_front();
            act_v = dut_vec();
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL state t=%0t got px=%0d py=%0d col=%0d row=%0d sx=%0d sy=%0d ia=%0b err=%0b want %h got %h",
                         $time, px, py, col, row, sub_x, sub_y, in_area, check_err, exp_v, act_v);
            end
        end
        total++;
`ifdef GLYPH_DIV3_CHECK_EN
        if (div_in !== exp_v[31:25]) begin
            bad++;
            $display("FAIL div_in got=%0d want=%0d", div_in, exp_v[31:25]);
        end
`else
        if (div_in !== 7'd0) begin
            bad++;
            $display("FAIL div_in_tied got=%0d want=0", div_in);
        end
`endif
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL reset_async got=%h want=%h", dut_vec(), model_vec());
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dut_vec() !== {7'd0, 7'd0, 6'd0, 6'd0, 2'd0, 2'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_held got=%h want=%h", dut_vec(), 32'h0000_0002);
        end
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 0, 0);
    endtask

    task automatic test_basic();
        cycle(1, 0, 0);
        repeat (15) cycle(0, 0, 1);
        total++;
        if ({px, col, sub_x, in_area} !== {7'd3, 6'd1, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL basic_15pix got px=%0d col=%0d sx=%0d ia=%0b want 3 1 0 1", px, col, sub_x, in_area);
        end
    endtask

    task automatic test_x_saturate();
        cycle(0, 1, 0);
        repeat (600) cycle(0, 0, 1);
        total++;
        if ({px, col, sub_x, in_area} !== {7'd119, 6'd39, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL x_sat got px=%0d col=%0d sx=%0d ia=%0b want 119 39 2 0", px, col, sub_x, in_area);
        end
        cycle(0, 1, 0);
        total++;
        if ({px, in_area} !== {7'd0, 1'b1}) begin
            bad++;
            $display("FAIL x_relatch got px=%0d ia=%0b want 0 1", px, in_area);
        end
    endtask

    task automatic test_y_sweep();
        cycle(1, 0, 0);
        repeat (12) cycle(0, 1, 0);
        total++;
        if ({py, row, sub_y} !== {7'd3, 6'd1, 2'd0}) begin
            bad++;
            $display("FAIL y_12 got py=%0d row=%0d sy=%0d want 3 1 0", py, row, sub_y);
        end
        for (int i = 0; i < 468; i++) begin
            cycle(0, 1, 0);
            if (i % 97 == 5) repeat (7) cycle(0, 0, 1);
        end
        total++;
        if ({py, row, in_area} !== {7'd119, 6'd39, 1'b0}) begin
            bad++;
            $display("FAIL y_sat got py=%0d row=%0d ia=%0b want 119 39 0", py, row, in_area);
        end
    endtask

    task automatic test_priority();
        cycle(1, 0, 0);
        repeat (250) cycle(0, 0, 1);
        cycle(0, 1, 1);
        repeat (250) cycle(0, 0, 1);
        cycle(0, 1, 0);
        repeat (250) cycle(0, 0, 1);
        total++;
        if (px !== 7'd50) begin
            bad++;
            $display("FAIL prio_setup got px=%0d want 50", px);
        end
        cycle(1, 1, 1);
        total++;
        if ({px, py, col, row, sub_x, sub_y, in_area} !== {7'd0, 7'd0, 6'd0, 6'd0, 2'd0, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL prio_frame got px=%0d py=%0d ia=%0b want 0 0 1", px, py, in_area);
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 0, 0);
        repeat (385) cycle(0, 0, 1);
        cycle(0, 1, 0);
        repeat (385) cycle(0, 0, 1);
        total++;
        if (px !== 7'd77) begin
            bad++;
            $display("FAIL areset_setup got px=%0d want 77", px);
        end
        #2 reset = 1'b1;
        #1;
        m_xcnt = 0;
        m_ycnt = 0;
        m_err  = 1'b0;
        total++;
        if ({px, py, col, row, sub_x, sub_y, in_area, check_err} !== {7'd0, 7'd0, 6'd0, 6'd0, 2'd0, 2'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL areset_mid got px=%0d col=%0d sx=%0d ia=%0b want 0 0 0 1", px, col, sub_x, in_area);
        end
        reset = 1'b0;
        repeat (15) cycle(0, 0, 1);
        total++;
        if ({px, col, sub_x, in_area} !== {7'd3, 6'd1, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL areset_restart got px=%0d col=%0d want 3 1", px, col);
        end
    endtask

    task automatic test_check();
        cycle(1, 0, 0);
        repeat (15) cycle(0, 0, 1);
        force_bad = 1'b1;
`ifdef GLYPH_DIV3_CHECK_EN
        m_err = 1'b1;
`endif
        cycle(0, 0, 0);
        force_bad = 1'b0;
        repeat (3) cycle(0, 0, 0);
        cycle(0, 1, 0);
        total++;
`ifdef GLYPH_DIV3_CHECK_EN
        if (check_err !== 1'b1) begin
            bad++;
            $display("FAIL check_sticky got=%0b want=1", check_err);
        end
`else
        if (check_err !== 1'b0) begin
            bad++;
            $display("FAIL check_tied got=%0b want=0", check_err);
        end
`endif
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset  = 1'b0;
        m_xcnt = 0;
        m_ycnt = 0;
        m_err  = 1'b0;
        cycle(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_x_saturate();
        test_y_sweep();
        test_priority();
        test_async_reset();
        test_check();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glyph_cell_tracker.md
GLYPH_CELL_TRACKER -- requirements
Module: glyph_cell_tracker

Interface
REQ-001 SHALL have parameter XSCALE, default 5, meaning pixel clocks per coarse x step (range 1..15).
REQ-002 SHALL have parameter YSCALE, default 4, meaning scanlines per coarse y step (range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse at the start of a frame.
REQ-006 SHALL have port line_end  input  1  one-cycle pulse at the end of each active line.
REQ-007 SHALL have port pix_en  input  1  high on each active-video pixel clock.
REQ-008 SHALL have ports px, py  output  7 each  coarse x and y coordinates, 0..119.
REQ-009 SHALL have ports col, row  output  6 each  glyph cell column and row, 0..39.
REQ-010 SHALL have ports sub_x, sub_y  output  2 each  position inside the cell, 0..2.
REQ-011 SHALL have port in_area  output  1  high while both coarse coordinates are inside the 120x120 grid.
REQ-012 SHALL have ports div_in (output, 7), div_q (input, 6) and check_err (output, 1), used for the lookup cross-check.

Function
REQ-013 All outputs SHALL be registered; the effect of an input sampled at edge N SHALL be visible after edge N.
REQ-014 Input priority SHALL be frame_start > line_end > pix_en when pulses coincide on one edge.
REQ-015 frame_start SHALL clear all x and y counters and prescalers and set in_area_x and in_area_y to 1.
REQ-016 pix_en SHALL increment the x prescaler; at XSCALE-1 it SHALL wrap to 0 and produce one x step.
REQ-017 On an x step with px<119: px SHALL increment; sub_x SHALL increment, and at 2 it SHALL wrap to 0 and increment col.
REQ-018 On an x step with px==119: in_area_x SHALL clear, and px, col and sub_x SHALL hold (saturate).
REQ-019 line_end SHALL clear the x prescaler, px, col and sub_x, set in_area_x to 1, and produce one y tick.
REQ-020 The y tick SHALL use the same prescale, step, wrap and saturate rules as x (REQ-016..018), with YSCALE, py, row, sub_y and in_area_y.
REQ-021 in_area SHALL equal in_area_x AND in_area_y.
REQ-022 Invariants SHALL hold at all times: col==px/3, sub_x==px%3, row==py/3, sub_y==py%3.
REQ-023 No divider or multiplier SHALL be used; quotient and remainder SHALL be tracked only by incremental counters.

Reset
REQ-024 reset SHALL immediately (asynchronously) drive:
- px, py, col, row, sub_x, sub_y, both prescalers, check_err to 0;
- in_area_x, in_area_y to 1.
REQ-025 reset asserted mid-line or mid-frame SHALL abandon all progress; after deassertion, counting SHALL restart from the reset state on the next qualifying input.

Configuration
REQ-026 Macro GLYPH_DIV3_CHECK_EN SHALL select the lookup cross-check.
REQ-027 With GLYPH_DIV3_CHECK_EN defined:
- div_in SHALL equal the current registered px;
- div_q is the combinational divide-by-3 lookup of div_in;
- on any edge with in_area high and div_q != col, check_err SHALL set and stay set until reset.
REQ-028 Without GLYPH_DIV3_CHECK_EN: div_in SHALL be driven 0, div_q SHALL be ignored, and check_err SHALL be tied 0.

Verification
REQ-029 Reset, then frame_start, then 15 pix_en cycles -> px=3, col=1, sub_x=0, in_area=1.
REQ-030 600 consecutive pix_en cycles after line_end -> px=119, col=39, sub_x=2, in_area=0; next line_end -> px=0, in_area=1.
REQ-031 12 line_end pulses after frame_start -> py=3, row=1, sub_y=0; after 480 pulses -> py=119, row=39, in_area=0.
REQ-032 frame_start, line_end and pix_en high on the same edge with px=50 -> all counters 0, in_area=1 (frame_start wins).
REQ-033 reset pulsed asynchronously between edges at px=77 -> outputs read 0 before the next edge; in_area=1.
REQ-034 With GLYPH_DIV3_CHECK_EN and a correct lookup model, sweep a full frame -> check_err=0; force div_q=5 while px=3 -> check_err=1 after the edge and held.
